// File: rtl/fetch_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch block.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INST_BYTES       = 4;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory request/response and decode-side instruction handshake.
interface fetch_pc_unit_if import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc, inst_pc_plus4,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc, inst_pc_plus4,
    output inst_ready
  );
endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC selection: sequential pc+4 or word-aligned redirect target.
module fetch_pc_sel import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned_d
);

  // Redirect target has its low two bits forced to zero; pc+4 wraps modulo 2^XLEN.
  always_comb begin
    next_pc      = pc + XLEN'(INST_BYTES);
    misaligned_d = 1'b0;
    if (redirect) begin
      next_pc      = {branch_target[XLEN-1:2], 2'b00};
      misaligned_d = |branch_target[1:0];
    end else begin
      next_pc      = pc + XLEN'(INST_BYTES);
      misaligned_d = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch with redirect squash.
module fetch_pc_unit import fetch_pkg::*; #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             NextPCSrc,
  input  logic             resolve_valid,
  input  logic [XLEN-1:0]  branch_target,
  fetch_pc_unit_if.master  bus,
  output logic             misaligned
);

  fetch_state_t    state_r, state_next_s;
  logic [XLEN-1:0] pc_r, pc_next_s, sel_pc_s;
  logic            discard_r, discard_next_s;
  logic            redirect_s, accept_s, load_s, misaligned_d_s;
  logic            req_valid_r, inst_valid_r, misaligned_r;
  logic [31:0]     inst_r;
  logic [XLEN-1:0] inst_pc_r, inst_pc_plus4_r;

  assign redirect_s = resolve_valid & NextPCSrc;
  assign accept_s   = req_valid_r & bus.imem_req_ready;

  fetch_pc_sel #(.XLEN(XLEN)) u_pc_sel (
    .pc            (pc_r),
    .redirect      (redirect_s),
    .branch_target (branch_target),
    .next_pc       (sel_pc_s),
    .misaligned_d  (misaligned_d_s)
  );

  // Next-state logic; a redirect overrides every other event in its cycle.
  always_comb begin
    state_next_s   = state_r;
    pc_next_s      = pc_r;
    discard_next_s = discard_r;
    load_s         = 1'b0;
    case (state_r)
      S_REQ: begin
        if (redirect_s) begin
          pc_next_s = sel_pc_s;
          if (accept_s) begin
            state_next_s   = S_WAIT;
            discard_next_s = 1'b1;
          end else begin
            state_next_s   = S_REQ;
          end
        end else if (accept_s) begin
          state_next_s = S_WAIT;
        end else begin
          state_next_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect_s) begin
          pc_next_s = sel_pc_s;
          if (bus.imem_rsp_valid) begin
            state_next_s   = S_REQ;
            discard_next_s = 1'b0;
          end else begin
            state_next_s   = S_WAIT;
            discard_next_s = 1'b1;
          end
        end else if (bus.imem_rsp_valid) begin
          if (discard_r) begin
            state_next_s   = S_REQ;
            discard_next_s = 1'b0;
          end else begin
            state_next_s = S_HOLD;
            pc_next_s    = sel_pc_s;
            load_s       = 1'b1;
          end
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect_s) begin
          pc_next_s    = sel_pc_s;
          state_next_s = S_REQ;
        end else if (bus.inst_ready) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      default: begin
        state_next_s   = S_REQ;
        discard_next_s = 1'b0;
      end
    endcase
  end

  // FSM, PC and discard flag; request valid is registered so it stays low in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      discard_r   <= 1'b0;
      req_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      discard_r   <= discard_next_s;
      req_valid_r <= (state_next_s == S_REQ);
    end
  end

  // Decode-facing output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_r    <= 1'b0;
      misaligned_r    <= 1'b0;
      inst_r          <= 32'h0000_0000;
      inst_pc_r       <= '0;
      inst_pc_plus4_r <= '0;
    end else begin
      inst_valid_r <= (state_next_s == S_HOLD);
      misaligned_r <= misaligned_d_s;
      if (load_s) begin
        inst_r          <= bus.imem_rsp_data;
        inst_pc_r       <= pc_r;
        inst_pc_plus4_r <= sel_pc_s;
      end
    end
  end

  assign bus.imem_req_valid = req_valid_r;
  assign bus.imem_addr      = pc_r;
  assign bus.inst_valid     = inst_valid_r;
  assign bus.inst           = inst_r;
  assign bus.inst_pc        = inst_pc_r;
  assign bus.inst_pc_plus4  = inst_pc_plus4_r;
  assign misaligned         = misaligned_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a transaction-level reference model.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        NextPCSrc, resolve_valid, misaligned, misaligned2;
  logic [31:0] branch_target;

  fetch_pc_unit_if #(.XLEN(32)) bus ();
  fetch_pc_unit_if #(.XLEN(32)) bus2 ();

  fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(NextPCSrc), .resolve_valid(resolve_valid),
    .branch_target(branch_target), .bus(bus), .misaligned(misaligned)
  );

  fetch_pc_unit #(.XLEN(32), .RESET_PC(RST_PC2)) dut2 (
    .clk(clk), .rst_n(rst_n), .NextPCSrc(1'b0), .resolve_valid(1'b0),
    .branch_target(32'h0000_0000), .bus(bus2), .misaligned(misaligned2)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    else return 32'hxxxx_xxxx;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory behaviour knobs, sampled by the responder on the falling edge
  int   mem_lat = 1;
  logic poison  = 1'b0;

  initial begin : mem_proc
    int          remaining;
    int          lat_s;
    logic        acc, poison_s;
    logic [31:0] a, pdata;
    remaining = 0;
    pdata = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc = bus.imem_req_valid && bus.imem_req_ready;
      a = bus.imem_addr;
      lat_s = mem_lat;
      poison_s = poison;
      @(posedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        remaining = 0;
      end else begin
        if (acc) begin
          remaining = lat_s;
          pdata = poison_s ? 32'hDEAD_BEEF : mem_word(a);
        end
        if (remaining > 0) begin
          remaining--;
          if (remaining == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = pdata;
          end
        end
      end
    end
  end

  logic [31:0] acc2_q[$];
  logic [31:0] pc2_q[$];
  logic [31:0] p42_q[$];

  initial begin : mem2_proc
    logic        acc2;
    logic [31:0] a2;
    bus2.imem_req_ready = 1'b1;
    bus2.inst_ready     = 1'b1;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc2 = bus2.imem_req_valid && bus2.imem_req_ready;
      a2 = bus2.imem_addr;
      if (rst_n && acc2) acc2_q.push_back(a2);
      if (rst_n && bus2.inst_valid && bus2.inst_ready) begin
        pc2_q.push_back(bus2.inst_pc);
        p42_q.push_back(bus2.inst_pc_plus4);
      end
      @(posedge clk);
      #1;
      bus2.imem_rsp_valid = rst_n && acc2;
      bus2.imem_rsp_data  = mem_word(a2);
    end
  end

  // Reference model state
  int          cyc = 0;
  logic [31:0] acc_log[$];
  int          acc_cyc[$];
  int          first_iv_cyc;
  logic [31:0] first_iv_pc, first_iv_p4;
  logic        saw_poison;

  task automatic clear_logs();
    acc_log.delete();
    acc_cyc.delete();
    first_iv_cyc = -1;
    saw_poison = 1'b0;
  endtask

  initial begin : model
    logic [31:0] exp_pc, a;
    logic        exp_mis, prev_hold, redir, xfer, sq;
    logic [31:0] out_a[$];
    logic        out_sq[$];
    logic [31:0] iq_d[$];
    logic [31:0] iq_pc[$];
    exp_pc = RST_PC; exp_mis = 1'b0; prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        out_a.delete(); out_sq.delete(); iq_d.delete(); iq_pc.delete();
        exp_pc = RST_PC; exp_mis = 1'b0; prev_hold = 1'b0;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'h0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        chk("rst_inst_pc_plus4", bus.inst_pc_plus4, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'h0);
      end else begin
        redir = resolve_valid && NextPCSrc;
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
        if (prev_hold) chk("hold_valid", 32'(bus.inst_valid), 32'h1);
        if (bus.inst_valid) begin
          if (first_iv_cyc < 0) begin
            first_iv_cyc = cyc;
            first_iv_pc = bus.inst_pc;
            first_iv_p4 = bus.inst_pc_plus4;
          end
          if (bus.inst == 32'hDEAD_BEEF) saw_poison = 1'b1;
          chk("inst_q_depth", 32'(iq_d.size()), 32'h1);
          if (iq_d.size() != 0) begin
            chk("inst", bus.inst, iq_d[0]);
            chk("inst_pc", bus.inst_pc, iq_pc[0]);
            chk("inst_pc_plus4", bus.inst_pc_plus4, iq_pc[0] + 32'd4);
          end
        end
        xfer = bus.inst_valid && bus.inst_ready && !redir;
        if (xfer && iq_d.size() != 0) begin
          void'(iq_d.pop_front());
          void'(iq_pc.pop_front());
        end
        if (bus.imem_req_valid) chk("outstanding_at_req", 32'(out_a.size()), 32'h0);
        if (bus.imem_rsp_valid) begin
          chk("outstanding_at_rsp", 32'(out_a.size()), 32'h1);
          if (out_a.size() != 0) begin
            a = out_a.pop_front();
            sq = out_sq.pop_front();
            if (!sq) begin
              iq_d.push_back(bus.imem_rsp_data);
              iq_pc.push_back(a);
            end
          end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          chk("req_addr", bus.imem_addr, exp_pc);
          acc_log.push_back(bus.imem_addr);
          acc_cyc.push_back(cyc);
          out_a.push_back(exp_pc);
          out_sq.push_back(1'b0);
          exp_pc = exp_pc + 32'd4;
        end
        if (redir) begin
          foreach (out_sq[i]) out_sq[i] = 1'b1;
          iq_d.delete();
          iq_pc.delete();
          exp_pc = {branch_target[31:2], 2'b00};
        end
        exp_mis = redir && (branch_target[1:0] != 2'b00);
        prev_hold = bus.inst_valid && !bus.inst_ready && !redir;
      end
    end
  end

  task automatic redirect(input logic [31:0] t);
    resolve_valid = 1'b1;
    NextPCSrc = 1'b1;
    branch_target = t;
    step(1);
    resolve_valid = 1'b0;
    NextPCSrc = 1'b0;
  endtask

  task automatic wait_req(input int lim);
    for (int i = 0; i < lim && !bus.imem_req_valid; i++) step(1);
    chk("wait_req_valid", 32'(bus.imem_req_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    NextPCSrc = 1'b0; resolve_valid = 1'b0; branch_target = 32'h0;
    bus.imem_req_ready = 1'b1; bus.inst_ready = 1'b1;
    step(3);

    // Straight-line fetch from reset with a zero-wait memory
    clear_logs();
    rst_n = 1'b1;
    step(12);
    chk("s1_addr0", q_at(acc_log, 0), 32'h0000_0000);
    chk("s1_addr1", q_at(acc_log, 1), 32'h0000_0004);
    chk("s1_addr2", q_at(acc_log, 2), 32'h0000_0008);
    chk("s1_first_pc", first_iv_pc, 32'h0000_0000);
    chk("s1_first_pc_plus4", first_iv_p4, 32'h0000_0004);
    chk("s1_latency", 32'(first_iv_cyc - ((acc_cyc.size() > 0) ? acc_cyc[0] : -100)), 32'd2);

    // Redirect while waiting for a response that must be dropped
    bus.imem_req_ready = 1'b0; mem_lat = 3; poison = 1'b1;
    wait_req(20);
    bus.imem_req_ready = 1'b1;
    step(1);
    redirect(32'h0000_0100);
    clear_logs();
    poison = 1'b0; mem_lat = 1;
    step(10);
    chk("s2_next_addr", q_at(acc_log, 0), 32'h0000_0100);
    chk("s2_no_poison", 32'(saw_poison), 32'h0);

    // Redirect while an instruction is held for decode
    redirect(32'h0000_0000);
    for (int i = 0; i < 60 && !(bus.imem_req_valid && bus.imem_addr == 32'h8); i++) step(1);
    bus.inst_ready = 1'b0;
    chk("s3_reach_8", bus.imem_addr, 32'h0000_0008);
    for (int i = 0; i < 20 && !bus.inst_valid; i++) step(1);
    step(2);
    chk("s3_hold_valid", 32'(bus.inst_valid), 32'h1);
    chk("s3_hold_pc", bus.inst_pc, 32'h0000_0008);
    chk("s3_hold_inst", bus.inst, 32'hA5C3_0008);
    bus.inst_ready = 1'b1;
    redirect(32'h0000_0040);
    clear_logs();
    chk("s3_valid_drop", 32'(bus.inst_valid), 32'h0);
    step(6);
    chk("s3_next_addr", q_at(acc_log, 0), 32'h0000_0040);

    // Not-taken resolutions in every state must not disturb the sequence
    redirect(32'h0000_0200);
    clear_logs();
    resolve_valid = 1'b1; NextPCSrc = 1'b0; branch_target = 32'hDEAD_0001; mem_lat = 2;
    for (int i = 0; i < 45; i++) begin
      bus.inst_ready = (i % 3 != 0);
      bus.imem_req_ready = (i % 4 != 1);
      step(1);
    end
    resolve_valid = 1'b0; bus.inst_ready = 1'b1; bus.imem_req_ready = 1'b1; mem_lat = 1;
    step(4);
    chk("s4_addr0", q_at(acc_log, 0), 32'h0000_0200);
    chk("s4_addr1", q_at(acc_log, 1), 32'h0000_0204);
    chk("s4_addr2", q_at(acc_log, 2), 32'h0000_0208);
    chk("s4_addr3", q_at(acc_log, 3), 32'h0000_020C);

    // Misaligned redirect target
    redirect(32'h0000_0103);
    clear_logs();
    chk("s5_mis_pulse", 32'(misaligned), 32'h1);
    step(1);
    chk("s5_mis_clear", 32'(misaligned), 32'h0);
    step(8);
    chk("s5_next_addr", q_at(acc_log, 0), 32'h0000_0100);

    // Asynchronous reset while a response is outstanding
    bus.imem_req_ready = 1'b0; mem_lat = 4;
    wait_req(20);
    bus.imem_req_ready = 1'b1;
    step(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_req_valid", 32'(bus.imem_req_valid), 32'h0);
    chk("s6_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("s6_inst", bus.inst, 32'h0);
    chk("s6_inst_pc", bus.inst_pc, 32'h0);
    chk("s6_inst_pc_plus4", bus.inst_pc_plus4, 32'h0);
    chk("s6_misaligned", 32'(misaligned), 32'h0);
    mem_lat = 1;
    step(3);
    clear_logs();
    rst_n = 1'b1;
    step(10);
    chk("s6_restart0", q_at(acc_log, 0), RST_PC);
    chk("s6_restart1", q_at(acc_log, 1), 32'h0000_0004);

    // Wrap-around from a top-of-memory reset vector
    chk("s7_addr0", q_at(acc2_q, 0), 32'hFFFF_FFFC);
    chk("s7_inst_pc", q_at(pc2_q, 0), 32'hFFFF_FFFC);
    chk("s7_inst_pc_plus4", q_at(p42_q, 0), 32'h0000_0000);
    chk("s7_addr1", q_at(acc2_q, 1), 32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
